vga_trace_writer: RTL and testbench

- Upstream feeder of the VGA trace display.
- Accepts ECG and EMG sample streams over valid/ready, decimates each stream, and writes the samples into two circular 640-entry regions of the shared signal memory. The display reads those regions back (ECG at base 0x801, EMG at base 0xC7F, indexed by screen x).
- Provides automatic and on-demand clearing of both regions, a freeze (hold) mode and per-channel sweep-complete pulses.

---
 rtl/vga_trace_writer_pkg.sv | 26 ++
 rtl/vga_trace_writer_channel.sv | 75 +++++++
 rtl/vga_trace_writer.sv | 149 ++++++++++++++
 tb/tb_vga_trace_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_trace_writer_pkg.sv
// Shared constants and helpers for the VGA trace writer and the trace display.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: region geometry defaults, writer state encoding and the
// sample-to-memory-word packing function used by writer and display alike.
package vga_trace_writer_pkg;

    localparam int          TRACE_WIDTH       = 640;     // entries per region, one per screen column
    localparam logic [11:0] TRACE_ECG_BASE    = 12'h801;
    localparam logic [11:0] TRACE_EMG_BASE    = 12'hC7F;
    localparam int          TRACE_DECIM       = 4;       // input samples per stored sample
    localparam logic [11:0] TRACE_CLEAR_VALUE = 12'h000;

    // Writer states, fixed encoding so the reset value is the clear state.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } trace_state_e;

    // Memory word layout: sample in the low 12 bits, upper bits zero.
    function automatic logic [31:0] pack_sample(input logic [11:0] s);
        return {20'b0, s};
    endfunction

endpackage

// File: rtl/vga_trace_writer_channel.sv
// One trace channel: decimates an incoming sample stream and holds one pending sample for the writer.
// Latency: a sample is pending from the edge that accepts every DECIM-th input; grant retires it on the next edge.
// Backpressure: src_ready drops while a sample is pending (unless freeze, where inputs are accepted and dropped).
//
// Ports: clock/reset; run (writer is accepting), clr (zero pointer, phase, pending);
// freeze; src_sample/src_valid/src_ready stream; grant from arbiter;
// pending/sample/wptr towards the writer; sweep pulses with the write to the last column.
module trace_channel
    import vga_trace_writer_pkg::*;
#(
    parameter int WIDTH = TRACE_WIDTH,
    parameter int DECIM = TRACE_DECIM
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        clr,
    input  logic        freeze,
    input  logic [11:0] src_sample,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic        grant,
    output logic        pending,
    output logic [11:0] sample,
    output logic [9:0]  wptr,
    output logic        sweep
);

    // One-bit counter when DECIM==1: it never leaves zero, so every sample is stored.
    localparam int             CW        = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DECIM - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [9:0]     WPTR_LAST = 10'(WIDTH - 1);

    logic [CW-1:0] dcnt;
    logic          accept;

    // While frozen the channel keeps ready high so producers never stall,
    // even with a sample still waiting for its write slot.
    assign src_ready = run && (!pending || freeze);
    assign accept    = src_valid && src_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dcnt    <= '0;
            pending <= 1'b0;
            sample  <= '0;
            wptr    <= '0;
            sweep   <= 1'b0;
        end else if (clr) begin
            dcnt    <= '0;
            pending <= 1'b0;
            wptr    <= '0;
            sweep   <= 1'b0;
        end else begin
            sweep <= grant && (wptr == WPTR_LAST);
            if (grant) begin
                pending <= 1'b0;
                wptr    <= (wptr == WPTR_LAST) ? '0 : wptr + 10'd1;
            end
            // A store can only happen while nothing is pending (ready implies
            // !pending when not frozen), so it never collides with a grant.
            if (accept && !freeze) begin
                if (dcnt == CNT_LAST) begin
                    pending <= 1'b1;
                    sample  <= src_sample;
                    dcnt    <= '0;
                end else begin
                    dcnt <= dcnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/vga_trace_writer.sv
// Writes decimated ECG/EMG samples into two circular display regions, with clear, freeze and sweep pulses.
// Latency: stored sample reaches the write port one edge later (two if it loses a tie); clear takes 2*WIDTH cycles.
// Backpressure: per-channel ready low while that channel holds a pending sample, and throughout clearing.
//
// Ports: clock, reset (async, active high); ecg_/emg_ sample/valid/ready streams;
// freeze, clear_req, busy; registered write port wr_en/wr_addr/wr_data;
// ecg_wptr/emg_wptr next write index; ecg_sweep/emg_sweep last-column pulses.
module vga_trace_writer
    import vga_trace_writer_pkg::*;
#(
    parameter int          WIDTH       = TRACE_WIDTH,
    parameter logic [11:0] ECG_BASE    = TRACE_ECG_BASE,
    parameter logic [11:0] EMG_BASE    = TRACE_EMG_BASE,
    parameter int          DECIM       = TRACE_DECIM,
    parameter logic [11:0] CLEAR_VALUE = TRACE_CLEAR_VALUE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] ecg_sample,
    input  logic        ecg_valid,
    output logic        ecg_ready,
    input  logic [11:0] emg_sample,
    input  logic        emg_valid,
    output logic        emg_ready,
    input  logic        freeze,
    input  logic        clear_req,
    output logic        busy,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [9:0]  ecg_wptr,
    output logic [9:0]  emg_wptr,
    output logic        ecg_sweep,
    output logic        emg_sweep
);

    // Parameter sanity, caught at elaboration.
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("vga_trace_writer: WIDTH must be 1..1024");
    end
    if (DECIM < 1) begin : g_bad_decim
        $error("vga_trace_writer: DECIM must be at least 1");
    end
    if (int'(ECG_BASE) + WIDTH - 1 > 4095) begin : g_bad_ecg_base
        $error("vga_trace_writer: ECG region exceeds 12-bit address space");
    end
    if (int'(EMG_BASE) + WIDTH - 1 > 4095) begin : g_bad_emg_base
        $error("vga_trace_writer: EMG region exceeds 12-bit address space");
    end

    localparam logic [10:0] W11      = 11'(WIDTH);
    localparam logic [10:0] CLR_LAST = 11'(2 * WIDTH - 1);

    trace_state_e state;
    logic [10:0]  clr_idx;
    logic         tie_emg;      // 1: EMG wins the next tie

    logic         run;
    logic         clearing;
    logic [10:0]  cidx;
    logic [11:0]  caddr;
    logic         ecg_pend, emg_pend;
    logic [11:0]  ecg_s, emg_s;
    logic         g_ecg, g_emg;

    // busy lines up with the clear writes on the port, so the cycle after the
    // final clear write (state already RUN) still keeps the inputs closed.
    assign run      = (state == ST_RUN) && !busy;
    // A clear request in RUN starts the clear on this very edge; its first
    // write takes the port, which is why a same-edge grant is dropped.
    assign clearing = (state == ST_CLEAR) || (run && clear_req);
    assign cidx     = (state == ST_CLEAR) ? clr_idx : '0;
    assign caddr    = (cidx < W11) ? ECG_BASE + {1'b0, cidx}
                                   : EMG_BASE + {1'b0, cidx - W11};

    assign g_ecg = run && !clear_req && ecg_pend && (!emg_pend || !tie_emg);
    assign g_emg = run && !clear_req && emg_pend && (!ecg_pend ||  tie_emg);

    trace_channel #(.WIDTH(WIDTH), .DECIM(DECIM)) u_ecg (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .clr        (clearing),
        .freeze     (freeze),
        .src_sample (ecg_sample),
        .src_valid  (ecg_valid),
        .src_ready  (ecg_ready),
        .grant      (g_ecg),
        .pending    (ecg_pend),
        .sample     (ecg_s),
        .wptr       (ecg_wptr),
        .sweep      (ecg_sweep)
    );

    trace_channel #(.WIDTH(WIDTH), .DECIM(DECIM)) u_emg (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .clr        (clearing),
        .freeze     (freeze),
        .src_sample (emg_sample),
        .src_valid  (emg_valid),
        .src_ready  (emg_ready),
        .grant      (g_emg),
        .pending    (emg_pend),
        .sample     (emg_s),
        .wptr       (emg_wptr),
        .sweep      (emg_sweep)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b0;
            tie_emg <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (clearing) begin
            wr_en   <= 1'b1;
            wr_addr <= caddr;
            wr_data <= pack_sample(CLEAR_VALUE);
            busy    <= 1'b1;
            if (cidx == CLR_LAST) begin
                state   <= ST_RUN;
                clr_idx <= '0;
            end else begin
                state   <= ST_CLEAR;
                clr_idx <= cidx + 11'd1;
            end
        end else begin
            busy  <= 1'b0;
            wr_en <= g_ecg || g_emg;
            if (g_ecg) begin
                wr_addr <= ECG_BASE + {2'b0, ecg_wptr};
                wr_data <= pack_sample(ecg_s);
            end else if (g_emg) begin
                wr_addr <= EMG_BASE + {2'b0, emg_wptr};
                wr_data <= pack_sample(emg_s);
            end
            // Round-robin only on contested cycles: the loser goes first next tie.
            if (ecg_pend && emg_pend && (g_ecg || g_emg)) begin
                tie_emg <= !tie_emg;
            end
        end
    end

endmodule

// File: tb/tb_vga_trace_writer.sv
// Self-checking bench for vga_trace_writer: cycle-level reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: stimulus waits on ready before offering directed samples.
module tb_vga_trace_writer;

    localparam int W   = 640;
    localparam int DEC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] ecg_sample = '0, emg_sample = '0;
    logic        ecg_valid = 1'b0, emg_valid = 1'b0;
    logic        freeze = 1'b0, clear_req = 1'b0;
    logic        ecg_ready, emg_ready, busy, wr_en, ecg_sweep, emg_sweep;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  ecg_wptr, emg_wptr;

    vga_trace_writer dut (
        .clock(clock), .reset(reset),
        .ecg_sample(ecg_sample), .ecg_valid(ecg_valid), .ecg_ready(ecg_ready),
        .emg_sample(emg_sample), .emg_valid(emg_valid), .emg_ready(emg_ready),
        .freeze(freeze), .clear_req(clear_req), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ecg_wptr(ecg_wptr), .emg_wptr(emg_wptr),
        .ecg_sweep(ecg_sweep), .emg_sweep(emg_sweep)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cpos;          // next clear index, -1 once running
    bit          m_busy, m_wen;
    bit          m_sw [2];
    logic [11:0] m_addr;
    logic [31:0] m_data;
    int          m_cnt [2];       // inputs seen since last store
    bit          m_pend [2];
    logic [11:0] m_samp [2];
    int          m_wptr [2];
    int          m_tie;           // channel that wins the next tie

    function automatic int mbase(input int c);
        return (c == 0) ? 32'h801 : 32'hC7F;
    endfunction

    function automatic bit m_ready(input int c);
        return (m_cpos < 0) && !m_busy && (!m_pend[c] || freeze);
    endfunction

    task automatic m_reset();
        m_cpos = 0; m_busy = 0; m_wen = 0; m_addr = '0; m_data = '0; m_tie = 0;
        for (int c = 0; c < 2; c++) begin
            m_sw[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_samp[c] = '0; m_wptr[c] = 0;
        end
    endtask

    task automatic m_step();
        bit          v [2];
        logic [11:0] s [2];
        bit          acc [2];
        bit          running;
        int          g;
        int          idx;
        v[0] = ecg_valid;  v[1] = emg_valid;
        s[0] = ecg_sample; s[1] = emg_sample;
        running = (m_cpos < 0) && !m_busy;
        for (int c = 0; c < 2; c++) acc[c] = v[c] && m_ready(c);
        m_sw[0] = 0; m_sw[1] = 0;
        if (m_cpos >= 0 || (running && clear_req)) begin
            idx    = (m_cpos >= 0) ? m_cpos : 0;
            m_wen  = 1;
            m_addr = (idx < W) ? 12'(32'h801 + idx) : 12'(32'hC7F + idx - W);
            m_data = 32'h0;
            m_busy = 1;
            m_cpos = (idx == 2 * W - 1) ? -1 : idx + 1;
            for (int c = 0; c < 2; c++) begin
                m_cnt[c] = 0; m_pend[c] = 0; m_wptr[c] = 0;
            end
        end else begin
            m_busy = 0;
            g = -1;
            if (m_pend[0] && m_pend[1]) begin
                g = m_tie; m_tie = 1 - m_tie;
            end else if (m_pend[0]) g = 0;
            else if (m_pend[1]) g = 1;
            m_wen = (g >= 0);
            if (g >= 0) begin
                m_addr    = 12'(mbase(g) + m_wptr[g]);
                m_data    = {20'b0, m_samp[g]};
                m_sw[g]   = (m_wptr[g] == W - 1);
                m_pend[g] = 0;
                m_wptr[g] = (m_wptr[g] + 1) % W;
            end
            for (int c = 0; c < 2; c++) begin
                if (acc[c] && !freeze) begin
                    if (m_cnt[c] == DEC - 1) begin
                        m_pend[c] = 1; m_samp[c] = s[c]; m_cnt[c] = 0;
                    end else begin
                        m_cnt[c]++;
                    end
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) m_reset();
            else       m_step();
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    typedef struct { logic [11:0] a; logic [31:0] d; bit se; bit sm; } wr_t;
    wr_t wlog [$];

    initial forever begin
        @(negedge clock);
        chk("wr_en",     32'(wr_en),     32'(m_wen));
        chk("wr_addr",   32'(wr_addr),   32'(m_addr));
        chk("wr_data",   32'(wr_data),   32'(m_data));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("ecg_ready", 32'(ecg_ready), 32'(m_ready(0)));
        chk("emg_ready", 32'(emg_ready), 32'(m_ready(1)));
        chk("ecg_wptr",  32'(ecg_wptr),  m_wptr[0]);
        chk("emg_wptr",  32'(emg_wptr),  m_wptr[1]);
        chk("ecg_sweep", 32'(ecg_sweep), 32'(m_sw[0]));
        chk("emg_sweep", 32'(emg_sweep), 32'(m_sw[1]));
        if (wr_en) wlog.push_back('{wr_addr, wr_data, ecg_sweep, emg_sweep});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock); #2;
    endtask

    task automatic drive(input bit ev, input logic [11:0] es, input bit mv, input logic [11:0] ms);
        ecg_valid = ev; ecg_sample = es; emg_valid = mv; emg_sample = ms;
        tick();
        ecg_valid = 0; emg_valid = 0;
    endtask

    task automatic send_ecg(input logic [11:0] s);
        int n = 0;
        while (!ecg_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("ecg_ready_timeout", 0, 1);
        drive(1, s, 0, 12'h0);
    endtask

    task automatic wait_clear(output int n);
        int guard = 0;
        n = 0;
        while (!busy && guard < 10) begin tick(); guard++; end
        while (busy && n < 3000) begin tick(); n++; end
        if (n >= 3000) chk("clear_timeout", 0, 1);
    endtask

    int nclr, cnt;

    initial begin
        // Reset, then the power-on clear.
        repeat (3) tick();
        reset = 0;
        wait_clear(nclr);
        chk("clear_len", nclr, 1280);
        chk("clear_writes", wlog.size(), 1280);
        if (wlog.size() == 1280) begin
            chk("clear_first", 32'(wlog[0].a),    32'h801);
            chk("clear_ecg_end", 32'(wlog[639].a), 32'hA80);
            chk("clear_emg_beg", 32'(wlog[640].a), 32'hC7F);
            chk("clear_last", 32'(wlog[1279].a),  32'hEFE);
            cnt = 0;
            foreach (wlog[i]) if (wlog[i].d != 0) cnt++;
            chk("clear_data_zero", cnt, 0);
        end
        chk("ecg_ready_after_clear", 32'(ecg_ready), 1);
        chk("emg_ready_after_clear", 32'(emg_ready), 1);

        // Decimation: samples 1..8 give two stores.
        wlog.delete();
        for (int i = 1; i <= 8; i++) send_ecg(12'(i));
        repeat (4) tick();
        chk("decim_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("decim_a0", 32'(wlog[0].a), 32'h801);
            chk("decim_d0", wlog[0].d, 4);
            chk("decim_a1", 32'(wlog[1].a), 32'h802);
            chk("decim_d1", wlog[1].d, 8);
        end
        chk("decim_wptr", 32'(ecg_wptr), 2);

        // Tie: both store together twice; priority alternates.
        wlog.delete();
        for (int i = 0; i < 3; i++) drive(1, 12'(i), 1, 12'(i));
        drive(1, 12'hABC, 1, 12'h123);
        repeat (4) tick();
        for (int i = 0; i < 3; i++) drive(1, 12'(i), 1, 12'(i));
        drive(1, 12'h111, 1, 12'h222);
        repeat (4) tick();
        chk("tie_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("tie1_first",  32'(wlog[0].a), 32'h803);
            chk("tie1_fdata",  wlog[0].d, 32'hABC);
            chk("tie1_second", 32'(wlog[1].a), 32'hC7F);
            chk("tie1_sdata",  wlog[1].d, 32'h123);
            chk("tie2_first",  32'(wlog[2].a), 32'hC80);
            chk("tie2_second", 32'(wlog[3].a), 32'h804);
        end

        // Sweep: fill ECG up to the last column, then wrap.
        wlog.delete();
        for (int k = 0; k < (W - 4) * DEC; k++) send_ecg(12'(k));
        repeat (3) tick();
        chk("sweep_writes", wlog.size(), W - 4);
        cnt = 0;
        foreach (wlog[i]) if (wlog[i].se) cnt++;
        chk("sweep_pulses", cnt, 1);
        if (wlog.size() > 0) begin
            chk("sweep_addr", 32'(wlog[wlog.size()-1].a), 32'hA80);
            chk("sweep_flag", 32'(wlog[wlog.size()-1].se), 1);
        end
        chk("sweep_wrap", 32'(ecg_wptr), 0);
        wlog.delete();
        for (int k = 0; k < DEC; k++) send_ecg(12'h3C0 + 12'(k));
        repeat (3) tick();
        if (wlog.size() == 1) chk("wrap_addr", 32'(wlog[0].a), 32'h801);
        else chk("wrap_count", wlog.size(), 1);

        // Freeze: leave ECG phase at 2, stream while frozen, then resume.
        send_ecg(12'h001); send_ecg(12'h002);
        repeat (2) tick();
        wlog.delete();
        freeze = 1;
        for (int i = 0; i < 100; i++) drive(1, 12'($urandom), 1, 12'($urandom));
        chk("frz_ecg_ready", 32'(ecg_ready), 1);
        chk("frz_emg_ready", 32'(emg_ready), 1);
        freeze = 0;
        tick();
        chk("frz_writes", wlog.size(), 0);
        chk("frz_ecg_wptr", 32'(ecg_wptr), 1);
        chk("frz_emg_wptr", 32'(emg_wptr), 2);
        send_ecg(12'h5A5); send_ecg(12'h777);
        repeat (3) tick();
        chk("frz_resume_count", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("frz_resume_addr", 32'(wlog[0].a), 32'h802);
            chk("frz_resume_data", wlog[0].d, 32'h777);
        end

        // Clear request on the edge where a grant is due.
        for (int k = 0; k < DEC - 1; k++) send_ecg(12'h010);
        wlog.delete();
        ecg_valid = 1; ecg_sample = 12'hBAD;
        tick();
        ecg_valid = 0; clear_req = 1;
        tick();
        clear_req = 0;
        wait_clear(nclr);
        chk("reclear_len", nclr, 1280);
        chk("reclear_writes", wlog.size(), 1280);
        cnt = 0;
        foreach (wlog[i]) if (wlog[i].d == 32'hBAD) cnt++;
        chk("reclear_lost", cnt, 0);
        chk("reclear_ecg_wptr", 32'(ecg_wptr), 0);
        chk("reclear_emg_wptr", 32'(emg_wptr), 0);
        wlog.delete();
        for (int k = 0; k < DEC - 1; k++) send_ecg(12'h020);
        repeat (3) tick();
        chk("reclear_no_early", wlog.size(), 0);
        send_ecg(12'h321);
        repeat (3) tick();
        if (wlog.size() == 1) chk("reclear_first", 32'(wlog[0].a), 32'h801);
        else chk("reclear_first_count", wlog.size(), 1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) freeze = !freeze;
            clear_req = ($urandom_range(0, 1999) == 0);
            drive($urandom_range(0, 3) != 0, 12'($urandom),
                  $urandom_range(0, 2) != 0, 12'($urandom));
        end
        freeze = 0; clear_req = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
